// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin arbiter and sequencer for the shared CPU register
//             bus. Serialises single read/write requests from NREQ masters
//             onto cs/op/addr/wr_data, returns ack and read data to the
//             winning requester.
//  Options  : BUS_ARBITER_FIXED_PRIO_EN - when defined, the lowest requester
//             index always wins and the last-grant pointer is not kept.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic              bus_cs,
   output logic              bus_op,
   output logic [AW-1:0]     bus_addr,
   output logic [DW-1:0]     bus_wr_data,
   input  logic [DW-1:0]     bus_rd_data
);

   // Requester index width; a single requester still needs one bit.
   localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   // Read-latency counter holds 1..RD_LAT.
   localparam int c_CNT_W = $clog2(RD_LAT + 1);

   localparam logic [c_PTR_W-1:0] c_LAST_IDX   = c_PTR_W'(NREQ - 1);
   localparam logic [c_PTR_W:0]   c_NREQ_EXT   = (c_PTR_W + 1)'(NREQ);
   localparam logic [c_CNT_W-1:0] c_RD_LAT_CNT = c_CNT_W'(RD_LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   logic [NREQ-1:0]      r_gnt;
   logic [NREQ-1:0]      r_ack;
   logic [DW-1:0]        r_rdata;
   logic                 r_busy;
   logic                 r_bus_cs;
   logic                 r_bus_op;
   logic [AW-1:0]        r_bus_addr;
   logic [DW-1:0]        r_bus_wr_data;
   logic [c_CNT_W-1:0]   r_cnt;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
   logic [c_PTR_W-1:0]   r_last;
   logic [c_PTR_W-1:0]   r_win;
`endif

   logic [c_PTR_W-1:0]   w_start;
   logic [2*NREQ-1:0]    w_dbl;
   logic [NREQ-1:0]      w_rot;
   logic [c_PTR_W-1:0]   w_off;
   logic [c_PTR_W:0]     w_sum;
   logic [c_PTR_W-1:0]   w_winner;
   logic                 w_sel_op;
   logic [AW-1:0]        w_sel_addr;
   logic [DW-1:0]        w_sel_wdata;
   logic [NREQ-1:0]      w_gnt_onehot;

   // Search start: one past the previous winner (round-robin) or index 0.
`ifdef BUS_ARBITER_FIXED_PRIO_EN
   assign w_start = '0;
`else
   assign w_start = (r_last == c_LAST_IDX) ? '0 : r_last + c_PTR_W'(1);
`endif

   // Rotate the request vector so the search start lands on bit 0.
   assign w_dbl = {req, req};
   assign w_rot = NREQ'(w_dbl >> w_start);

   // Lowest set bit of the rotated vector is the offset of the winner.
   always_comb begin
      w_off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = c_PTR_W'(i);
         end
      end
   end

   // Undo the rotation modulo NREQ to get the absolute winner index.
   assign w_sum    = {1'b0, w_start} + {1'b0, w_off};
   assign w_winner = (w_sum >= c_NREQ_EXT) ? c_PTR_W'(w_sum - c_NREQ_EXT)
                                           : w_sum[c_PTR_W-1:0];

   // Pick out the winner's op/addr/wdata and build its one-hot grant.
   always_comb begin
      w_sel_op     = 1'b0;
      w_sel_addr   = '0;
      w_sel_wdata  = '0;
      w_gnt_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == c_PTR_W'(i)) begin
            w_sel_op        = req_op[i];
            w_sel_addr      = req_addr[i*AW +: AW];
            w_sel_wdata     = req_wdata[i*DW +: DW];
            w_gnt_onehot[i] = 1'b1;
         end
      end
   end

   // Transaction sequencer: arbitrate, issue, wait for read data, complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_gnt         <= '0;
         r_ack         <= '0;
         r_rdata       <= '0;
         r_busy        <= 1'b0;
         r_bus_cs      <= 1'b0;
         r_bus_op      <= 1'b0;
         r_bus_addr    <= '0;
         r_bus_wr_data <= '0;
         r_cnt         <= '0;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
         r_last        <= c_LAST_IDX;
         r_win         <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  // Fields are latched here; later changes by the
                  // requester have no effect on this transaction.
                  r_gnt         <= w_gnt_onehot;
                  r_bus_op      <= w_sel_op;
                  r_bus_addr    <= w_sel_addr;
                  r_bus_wr_data <= w_sel_wdata;
                  r_bus_cs      <= 1'b1;
                  r_busy        <= 1'b1;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
                  r_win         <= w_winner;
`endif
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_bus_cs <= 1'b0;
               if (r_bus_op) begin
                  r_ack   <= r_gnt;
                  r_state <= S_DONE;
               end else begin
                  r_cnt   <= c_CNT_W'(1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // r_cnt is the number of the WAIT cycle now in progress.
               if (r_cnt == c_RD_LAT_CNT) begin
                  r_rdata <= bus_rd_data;
                  r_ack   <= r_gnt;
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt   <= r_cnt + c_CNT_W'(1);
               end
            end
            S_DONE: begin
               r_ack   <= '0;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
`ifndef BUS_ARBITER_FIXED_PRIO_EN
               r_last  <= r_win;
`endif
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign ack         = r_ack;
   assign rdata       = r_rdata;
   assign busy        = r_busy;
   assign bus_cs      = r_bus_cs;
   assign bus_op      = r_bus_op;
   assign bus_addr    = r_bus_addr;
   assign bus_wr_data = r_bus_wr_data;

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit CPU register bus (cs/op/addr/wr_data/rd_data).
- Accepts single read/write requests from NREQ independent masters (sequences, config engines, DMA stubs), serialises them onto the bus, and returns an ack and read data to the winning requester.
- Sits between requester logic and the DUT register bus; owns all bus outputs.

Parameters:
- NREQ, 4, number of requesters (1..8)
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 2, cycles from issue cycle to bus_rd_data valid (>=1)

Ports:
- clk  in  1  bus clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester transaction request (level)
- req_op  in  NREQ  per-requester op, 1=write 0=read
- req_addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data, same packing
- gnt  out  NREQ  one-hot, high for the whole transaction of the winner
- ack  out  NREQ  one-hot single-cycle completion pulse
- rdata  out  DW  read data, valid in ack cycle for reads
- busy  out  1  high whenever state != IDLE
- bus_cs  out  1  bus chip select
- bus_op  out  1  bus op, 1=write 0=read
- bus_addr  out  AW  bus address
- bus_wr_data  out  DW  bus write data
- bus_rd_data  in  DW  bus read data from DUT

Behaviour:
- Clock and reset: one clock `clk`, asynchronous active-low reset `rst_n`. All outputs are registered.
- Reset values: all outputs 0; state=IDLE; last-grant pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin: the first set bit searching upward from last_grant+1, wrapping modulo NREQ.
  - Latch the winner's op, addr and wdata; set gnt[winner]; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - bus_cs=1; bus_op, bus_addr and bus_wr_data carry the latched values.
  - Write: go to DONE. Read: go to WAIT.
  - bus_cs returns to 0 on leaving ISSUE. bus_addr, bus_op and bus_wr_data hold their values until the next ISSUE.
- WAIT:
  - Lasts RD_LAT cycles. bus_rd_data is captured into rdata at the rising edge ending the RD_LAT-th cycle after ISSUE; then go to DONE.
- DONE (1 cycle):
  - ack[winner]=1. rdata holds the captured read data for reads; it is unchanged for writes.
  - last_grant updates to winner. gnt clears at the end of DONE. Go to IDLE.
- Latency per transaction, measured from req sampled in IDLE to ack: write 2 cycles, read 2+RD_LAT cycles. Minimum back-to-back spacing is 3 cycles (write) and 3+RD_LAT cycles (read).
- Requester rules:
  - Hold req, req_op, req_addr and req_wdata stable until ack.
  - Deassert req in the cycle after ack; otherwise a new transaction is started for that requester.
- Changes to the winner's request fields after latch are ignored.
- If req drops before ack, the transaction still completes and ack is still pulsed. No abort.
- Simultaneous requests: exactly one winner per arbitration. With all NREQ requesting continuously, grant order rotates 0,1,...,NREQ-1,0.
- NREQ=1: always grants requester 0.
- Reset asserted mid-transaction: immediate return to reset values. bus_cs drops asynchronously and no ack is issued.
- Widths: addr and data pass through unmodified, with no arithmetic on them. The RD_LAT counter is $clog2(RD_LAT+1) bits and saturates at no value.

Optional Feature:
- BUS_ARBITER_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. last_grant is not used and is not updated.
  - Undefined (default): round-robin as specified above.
  - All other timing is identical in both modes.

Test Plan:
- Single write, NREQ=4, RD_LAT=2: req[2]=1, op=1, addr=16'h0010, wdata=16'hA5A5 -> next cycle bus_cs=1, bus_op=1, bus_addr=16'h0010, bus_wr_data=16'hA5A5. ack[2] pulses 2 cycles after req is sampled. gnt=4'b0100 throughout.
- Single read: req[0] read addr=16'h0020, DUT drives bus_rd_data=16'h1234 two cycles after cs -> ack[0] at cycle 4 with rdata=16'h1234. busy is high from cycles 1 to 4.
- Contention: req=4'b1111 held, each deasserted the cycle after its ack -> ack order 0,1,2,3. With BUS_ARBITER_FIXED_PRIO_EN and req[0] re-raised after its ack, requester 0 wins every time over requesters 1..3.
- Round-robin wrap: last winner 3, then req=4'b1001 -> requester 0 wins. Next arbitration with req[3] still set -> requester 3 wins.
- Reset mid-read: assert rst_n=0 during WAIT -> bus_cs=0, gnt=0, ack=0, rdata=0 immediately. After release, a new req[1] write completes normally with requester 1 granted.
- Early req drop: req[1] deasserted during ISSUE -> the bus cycle still completes and ack[1] still pulses once. No second transaction is started.
